run_sequencer: RTL
==================

Name: run_sequencer

Overview:
- Top-level run controller for the 9-bit-instruction core.
- Handles the req/done handshake with the bench and loads the PC with the program start address.
- Gates core state updates (PC advance, register-file and data-memory writes) so the core only advances while a program is running.
- Detects the decoded halt instruction, enforces a cycle-count watchdog, and reports a cycle count for the completed run.

Parameters:
- D, 12, program counter width; matches the PC module.
- START, 0, program start address loaded into the PC at launch (D bits).
- CW, 16, width of the cycle counter.
- MAX_CYC, 4096, watchdog limit in RUN cycles; 0 disables the watchdog.
- DRAIN_CYC, 2, idle cycles between halt detection and done (1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  start request from the bench; a run launches on a 0->1 transition.
- halt  input  1  from the control decoder: the current instruction is the halt encoding.
- pc_load  output  1  one-cycle strobe: the PC loads pc_load_val.
- pc_load_val  output  D  PC load value; always equals START.
- core_en  output  1  qualifies PC advance, RegWrite and MemWrite in the core.
- busy  output  1  high in LAUNCH, RUN and DRAIN.
- done  output  1  run complete; held high in DONE.
- timeout  output  1  the last run ended on the watchdog; valid while done=1.
- cycle_cnt  output  CW  number of RUN cycles in the current or last run.

Behaviour:
- Reset (async, immediate): state=IDLE, req_q=0, pc_load=0, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0, drain counter=0. Reset mid-run aborts the run with no done pulse.
- req_q is req registered once. Launch condition: req=1 and req_q=0.
- All outputs are registered-state decodes: a Moore machine, no combinational path from inputs to outputs.
- State IDLE:
  - core_en=0, busy=0, done=0.
  - On the launch condition -> LAUNCH.
- State LAUNCH (exactly 1 cycle):
  - pc_load=1, core_en=0, busy=1.
  - cycle_cnt cleared to 0 and timeout cleared at this edge.
  - halt is ignored.
  - -> RUN.
- State RUN:
  - core_en=1, busy=1. Each cycle, cycle_cnt increments by 1, saturating at all-ones.
  - If halt=1 -> DRAIN. The halt cycle itself is counted, and core_en stays 1 in that cycle.
  - Else if MAX_CYC!=0 and cycle_cnt==MAX_CYC-1 -> DONE with timeout set to 1; that cycle is counted, so cycle_cnt reads MAX_CYC.
  - If halt and the watchdog fire in the same cycle, halt wins: -> DRAIN, timeout=0.
  - req changes are ignored, including deassertion.
- State DRAIN:
  - core_en=0, busy=1. The drain counter loads DRAIN_CYC-1 on entry and decrements each cycle; -> DONE when it reaches 0.
  - cycle_cnt holds.
- State DONE:
  - done=1, busy=0, core_en=0. cycle_cnt and timeout hold.
  - -> IDLE when req=0.
  - If req stays high, remain in DONE. No relaunch without a fresh 0->1 edge on req.
- pc_load is high only in LAUNCH.
- busy and done are never high together.
- In RUN, core_en is 1 for exactly cycle_cnt cycles of the run.
- Latency: req rise at edge N -> LAUNCH at N+1 -> first core_en=1 cycle at N+2.
- Latency: halt sampled at edge H -> done=1 after edge H+DRAIN_CYC.

Test Plan:
- Reset then idle, req=0 for 10 cycles -> state IDLE, core_en=0, done=0, pc_load never asserted, cycle_cnt=0.
- req rises, halt pulses on the 5th RUN cycle, DRAIN_CYC=2 -> one pc_load pulse with pc_load_val=0; core_en high for 5 cycles; done rises 2 cycles after the halt edge; cycle_cnt=5, timeout=0.
- MAX_CYC=8, halt never asserted -> done after 8 RUN cycles, cycle_cnt=8, timeout=1, no DRAIN cycles.
- MAX_CYC=8, halt asserted exactly on RUN cycle 8 -> DRAIN entered, timeout=0, cycle_cnt=8.
- req held high through DONE for 20 cycles -> done stays 1, no relaunch; then req 1->0->1 -> new LAUNCH with cycle_cnt cleared to 0 and timeout cleared.
- reset asserted asynchronously mid-RUN (cycle_cnt=3) -> immediately core_en=0, busy=0, cycle_cnt=0, state IDLE; no done pulse.

Source files
------------

// File: rtl/run_sequencer.sv
// Run controller for the 9-bit-instruction core.
// Launches a program on a rising edge of req, gates core state updates while the
// program runs, stops on the decoded halt instruction or the cycle watchdog,
// and reports how many RUN cycles the run took.
module run_sequencer #(
    parameter int unsigned D         = 12,
    parameter int unsigned START     = 0,
    parameter int unsigned CW        = 16,
    parameter int unsigned MAX_CYC   = 4096,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    output logic          pc_load,
    output logic [D-1:0]  pc_load_val,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Watchdog fires on the RUN cycle whose pre-increment count is MAX_CYC-1,
    // so the count reads exactly MAX_CYC once the run has ended.
    localparam bit            WdEn      = (MAX_CYC != 0);
    localparam logic [CW-1:0] WdLast    = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] CntMax    = {CW{1'b1}};
    localparam logic [3:0]    DrainLoad = 4'(DRAIN_CYC - 1);

    state_e     state_q;
    logic       req_q;
    logic [3:0] drain_cnt_q;

    assign pc_load_val = D'(START);

    // Sequencer: next state and every output are registered together, so no
    // input reaches an output without passing through a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            drain_cnt_q <= 4'd0;
            pc_load     <= 1'b0;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            req_q <= req;
            unique case (state_q)
                StIdle: begin
                    if (req && !req_q) begin
                        state_q   <= StLaunch;
                        pc_load   <= 1'b1;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                        timeout   <= 1'b0;
                    end
                end

                // Single cycle for the PC to take the start address; halt is
                // ignored because the decoded instruction is not yet valid.
                StLaunch: begin
                    state_q <= StRun;
                    pc_load <= 1'b0;
                    core_en <= 1'b1;
                end

                StRun: begin
                    if (cycle_cnt != CntMax) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    // Halt takes priority over a watchdog expiring in the same cycle.
                    if (halt) begin
                        state_q     <= StDrain;
                        core_en     <= 1'b0;
                        drain_cnt_q <= DrainLoad;
                    end else if (WdEn && (cycle_cnt == WdLast)) begin
                        state_q <= StDone;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end

                // Lets in-flight core activity settle before reporting done.
                StDrain: begin
                    if (drain_cnt_q == 4'd0) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 4'd1;
                    end
                end

                // Hold the result until the bench drops req; a relaunch then
                // needs a fresh rising edge seen from IDLE.
                StDone: begin
                    if (!req) begin
                        state_q <= StIdle;
                        done    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    pc_load <= 1'b0;
                    core_en <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
